axil_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank: the next-generation control/status front end for the accelerator IP, generalised from a fixed 4×32-bit register set. It provides NUM_RW software-writable control registers with byte strobes and write-pulse outputs, plus NUM_RO read-only status registers with read-pulse outputs for clear-on-read logic in the core. It sits between the processor's AXI4-Lite master and the accelerator datapath.

---
 rtl/axil_regbank_pkg.sv | 21 ++
 rtl/axil_hold_slot.sv | 47 ++++
 rtl/axil_regbank.sv | 184 ++++++++++++++++++
 tb/tb_axil_regbank.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_regbank_pkg.sv
// Shared constants, the address-class enum and a constant-width helper
// for the AXI4-Lite register bank.
package axil_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        CLASS_RW       = 2'd0,
        CLASS_RO       = 2'd1,
        CLASS_UNMAPPED = 2'd2
    } idx_class_e;

    function automatic int clog2(input int value);
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) >= value) return r;
        end
        return 31;
    endfunction

endpackage

// File: rtl/axil_hold_slot.sv
// One-entry holding register: accepts a beat when empty, keeps it until the
// owner clears it. Used to decouple the AW and W channels.
module axil_hold_slot
    import axil_regbank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // en holds ready low until the first clock after reset release.
    assign in_ready  = en && !valid_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) valid_d = 1'b0;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank: NUM_RW byte-strobed control registers with
// write pulses, NUM_RO status registers with read pulses for clear-on-read.
module axil_regbank
    import axil_regbank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_RW = 8,
    parameter int NUM_RO = 4,
    parameter int ADDR_W = 6
) (
    input  logic                                       ACLK,
    input  logic                                       ARESETN,
    input  logic [ADDR_W-1:0]                          AWADDR,
    input  logic [2:0]                                 AWPROT,
    input  logic                                       AWVALID,
    output logic                                       AWREADY,
    input  logic [DATA_W-1:0]                          WDATA,
    input  logic [DATA_W/8-1:0]                        WSTRB,
    input  logic                                       WVALID,
    output logic                                       WREADY,
    output logic [1:0]                                 BRESP,
    output logic                                       BVALID,
    input  logic                                       BREADY,
    input  logic [ADDR_W-1:0]                          ARADDR,
    input  logic [2:0]                                 ARPROT,
    input  logic                                       ARVALID,
    output logic                                       ARREADY,
    output logic [DATA_W-1:0]                          RDATA,
    output logic [1:0]                                 RRESP,
    output logic                                       RVALID,
    input  logic                                       RREADY,
    output logic [NUM_RW*DATA_W-1:0]                   reg_q,
    output logic [NUM_RW-1:0]                          reg_wr_pulse,
    input  logic [(NUM_RO > 0 ? NUM_RO : 1)*DATA_W-1:0] ro_d,
    output logic [(NUM_RO > 0 ? NUM_RO : 1)-1:0]        ro_rd_pulse
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int RO_N   = (NUM_RO > 0) ? NUM_RO : 1;

    function automatic idx_class_e classify(input logic [IDX_W-1:0] idx);
        if (int'(idx) < NUM_RW)               return CLASS_RW;
        else if (int'(idx) < NUM_RW + NUM_RO) return CLASS_RO;
        else                                  return CLASS_UNMAPPED;
    endfunction

    // Every channel: a beat transfers on a clock edge where VALID and READY are
    // both high; VALID never depends on READY and stays high with stable payload
    // until that edge.
    logic                     rst_done_q;
    logic                     aw_full, w_full, commit;
    logic [ADDR_W-1:0]        aw_addr;
    logic [DATA_W+STRB_W-1:0] w_beat;
    logic [DATA_W-1:0]        w_data;
    logic [STRB_W-1:0]        w_strb;
    logic [IDX_W-1:0]         w_idx, r_idx;
    idx_class_e               w_class, r_class;
    logic                     ar_hs;

    logic [NUM_RW*DATA_W-1:0] regs_q, regs_d;
    logic [NUM_RW-1:0]        wr_pulse_q, wr_pulse_d;
    logic                     bvalid_q, bvalid_d;
    logic [1:0]               bresp_q, bresp_d;
    logic                     rvalid_q, rvalid_d;
    logic [1:0]               rresp_q, rresp_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;
    logic [RO_N-1:0]          rd_pulse_q, rd_pulse_d;

    axil_hold_slot #(.WIDTH(ADDR_W)) u_aw_slot (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .en       (rst_done_q),
        .in_valid (AWVALID),
        .in_data  (AWADDR),
        .in_ready (AWREADY),
        .clr      (commit),
        .out_valid(aw_full),
        .out_data (aw_addr)
    );

    axil_hold_slot #(.WIDTH(DATA_W + STRB_W)) u_w_slot (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .en       (rst_done_q),
        .in_valid (WVALID),
        .in_data  ({WSTRB, WDATA}),
        .in_ready (WREADY),
        .clr      (commit),
        .out_valid(w_full),
        .out_data (w_beat)
    );

    assign {w_strb, w_data} = w_beat;
    assign w_idx   = aw_addr[ADDR_W-1:OFF_W];
    assign w_class = classify(w_idx);
    assign commit  = aw_full && w_full && (!bvalid_q || BREADY);

    assign r_idx   = ARADDR[ADDR_W-1:OFF_W];
    assign r_class = classify(r_idx);
    assign ARREADY = rst_done_q && !rvalid_q;
    assign ar_hs   = ARVALID && ARREADY;

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        if (bvalid_q && BREADY) bvalid_d = 1'b0;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = (w_class == CLASS_RW) ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_RW; i++) begin
                if (w_class == CLASS_RW && int'(w_idx) == i) begin
                    wr_pulse_d[i] = 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb[b]) regs_d[i*DATA_W + b*8 +: 8] = w_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Reads see regs_q, so a same-edge commit to the same register returns old data.
    always_comb begin
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        rd_pulse_d = '0;
        if (rvalid_q && RREADY) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = (r_class == CLASS_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
            for (int i = 0; i < NUM_RW; i++) begin
                if (int'(r_idx) == i) rdata_d = regs_q[i*DATA_W +: DATA_W];
            end
            for (int k = 0; k < NUM_RO; k++) begin
                if (int'(r_idx) == NUM_RW + k) begin
                    rdata_d       = ro_d[k*DATA_W +: DATA_W];
                    rd_pulse_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rst_done_q <= 1'b0;
            regs_q     <= '0;
            wr_pulse_q <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
            rd_pulse_q <= '0;
        end else begin
            rst_done_q <= 1'b1;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

    assign reg_q        = regs_q;
    assign reg_wr_pulse = wr_pulse_q;
    assign BVALID       = bvalid_q;
    assign BRESP        = bresp_q;
    assign RVALID       = rvalid_q;
    assign RRESP        = rresp_q;
    assign RDATA        = rdata_q;
    assign ro_rd_pulse  = rd_pulse_q;

    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, aw_addr[OFF_W-1:0], ARADDR[OFF_W-1:0]};

endmodule

// File: tb/tb_axil_regbank.sv
// Self-checking bench for axil_regbank at default parameters: directed
// scenarios plus randomised back-to-back traffic against a register model.
module tb_axil_regbank;
    import axil_regbank_pkg::*;

    localparam int DATA_W = 32;
    localparam int NUM_RW = 8;
    localparam int NUM_RO = 4;
    localparam int ADDR_W = 6;

    logic                       ACLK = 1'b0;
    logic                       ARESETN;
    logic [ADDR_W-1:0]          AWADDR, ARADDR;
    logic [2:0]                 AWPROT, ARPROT;
    logic                       AWVALID, AWREADY, WVALID, WREADY;
    logic [DATA_W-1:0]          WDATA, RDATA;
    logic [DATA_W/8-1:0]        WSTRB;
    logic [1:0]                 BRESP, RRESP;
    logic                       BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
    logic [NUM_RW*DATA_W-1:0]   reg_q;
    logic [NUM_RW-1:0]          reg_wr_pulse;
    logic [NUM_RO*DATA_W-1:0]   ro_d;
    logic [NUM_RO-1:0]          ro_rd_pulse;

    axil_regbank #(.DATA_W(DATA_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .ADDR_W(ADDR_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .ro_d(ro_d), .ro_rd_pulse(ro_rd_pulse)
    );

    // ---------------- clock / reset ----------------
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [1:0]        exp_bresp_q[$];
    logic [DATA_W-1:0] exp_rdata_q[$];
    logic [1:0]        exp_rresp_q[$];
    logic [DATA_W-1:0] model[NUM_RW];
    logic [NUM_RW-1:0] last_wr_pulse, post_wr_pulse;
    logic [NUM_RO-1:0] last_rd_pulse, post_rd_pulse;
    int                last_b_lat;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] d,
                                                input logic [DATA_W/8-1:0] s);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < DATA_W/8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [NUM_RW*DATA_W-1:0] model_flat();
        logic [NUM_RW*DATA_W-1:0] f;
        for (int i = 0; i < NUM_RW; i++) f[i*DATA_W +: DATA_W] = model[i];
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_aw_w(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [DATA_W/8-1:0] s, input int w_lead,
                             input logic [1:0] exp_resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int c = 0;
        int idx = int'(a[ADDR_W-1:2]);
        exp_bresp_q.push_back(exp_resp);
        if (idx < NUM_RW) model[idx] = merge(model[idx], d, s);
        AWADDR = a; WDATA = d; WSTRB = s;
        WVALID = 1'b1;
        AWVALID = (w_lead == 0);
        while (!(aw_done && w_done)) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(posedge ACLK); #1;
            c++;
            if (aw_hs) begin AWVALID = 1'b0; aw_done = 1; end
            if (w_hs)  begin WVALID = 1'b0;  w_done = 1;  end
            if (!aw_done && c >= w_lead) AWVALID = 1'b1;
            if (c > 60) begin
                checks++; errors++;
                $display("FAIL aw_w_accept_timeout: aw_done=%0b w_done=%0b required both 1", aw_done, w_done);
                AWVALID = 1'b0; WVALID = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_b();
        int n = 0;
        logic [1:0] exp;
        BREADY = 1'b1;
        while (!BVALID && n < 50) begin @(posedge ACLK); #1; n++; end
        last_b_lat    = n;
        last_wr_pulse = reg_wr_pulse;
        checks++;
        if (!BVALID || exp_bresp_q.size() == 0) begin
            errors++;
            $display("FAIL b_response: BVALID=%0b pending=%0d required BVALID=1 with pending>0", BVALID, exp_bresp_q.size());
        end else begin
            exp = exp_bresp_q.pop_front();
            if (BRESP !== exp) begin
                errors++;
                $display("FAIL bresp: got %b required %b", BRESP, exp);
            end
        end
        @(posedge ACLK); #1;
        post_wr_pulse = reg_wr_pulse;
    endtask

    task automatic write_txn(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [DATA_W/8-1:0] s, input int w_lead,
                             input logic [1:0] exp_resp);
        send_aw_w(a, d, s, w_lead, exp_resp);
        wait_b();
    endtask

    task automatic read_txn(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp_d,
                            input logic [1:0] exp_r, input int hold);
        int n = 0;
        logic [DATA_W-1:0] held;
        exp_rdata_q.push_back(exp_d);
        exp_rresp_q.push_back(exp_r);
        RREADY = (hold == 0);
        ARADDR = a; ARVALID = 1'b1;
        while (!ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
        last_rd_pulse = ro_rd_pulse;
        held = RDATA;
        for (int i = 0; i < hold; i++) begin
            @(posedge ACLK); #1;
            checks++;
            if (RVALID !== 1'b1 || RDATA !== held) begin
                errors++;
                $display("FAIL r_hold: RVALID=%0b RDATA=%h required 1 / %h", RVALID, RDATA, held);
            end
        end
        RREADY = 1'b1;
        checks++;
        if (!RVALID || exp_rdata_q.size() == 0) begin
            errors++;
            $display("FAIL r_response: RVALID=%0b required 1", RVALID);
        end else begin
            exp_d = exp_rdata_q.pop_front();
            exp_r = exp_rresp_q.pop_front();
            if (RDATA !== exp_d || RRESP !== exp_r) begin
                errors++;
                $display("FAIL rdata_rresp: got %h/%b required %h/%b", RDATA, RRESP, exp_d, exp_r);
            end
        end
        @(posedge ACLK); #1;
        post_rd_pulse = ro_rd_pulse;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ARESETN = 1'b0;
        AWADDR = '0; AWPROT = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0;
        BREADY = 1; ARADDR = '0; ARPROT = '0; ARVALID = 0; RREADY = 1; ro_d = '0;
        for (int i = 0; i < NUM_RW; i++) model[i] = '0;
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake: got %b required 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        checks++;
        if (reg_q !== '0 || reg_wr_pulse !== '0 || ro_rd_pulse !== '0 || RDATA !== '0 || {BRESP, RRESP} !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs: reg_q=%h RDATA=%h resp=%b required zero", reg_q, RDATA, {BRESP, RRESP});
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        checks++;
        if (AWREADY !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: AWREADY=%0b required 0", AWREADY);
        end
        @(posedge ACLK); #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_release: got %b required 111", {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_basic_write_read();
        write_txn(6'h00, 32'hDEADBEEF, 4'hF, 0, RESP_OKAY);
        checks++;
        if (reg_q[31:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_reg_q: got %h required DEADBEEF", reg_q[31:0]);
        end
        checks++;
        if (last_wr_pulse !== 8'h01 || post_wr_pulse !== 8'h00) begin
            errors++; $display("FAIL basic_pulse: got %h then %h required 01 then 00", last_wr_pulse, post_wr_pulse);
        end
        checks++;
        if (last_b_lat !== 1) begin
            errors++; $display("FAIL basic_b_latency: got %0d required 1", last_b_lat);
        end
        read_txn(6'h00, 32'hDEADBEEF, RESP_OKAY, 0);
    endtask

    task automatic test_w_first_strobe();
        write_txn(6'h04, 32'hAABBCCDD, 4'hF, 0, RESP_OKAY);
        write_txn(6'h04, 32'h11223344, 4'h5, 3, RESP_OKAY);
        checks++;
        if (reg_q[63:32] !== 32'hAA22CC44) begin
            errors++; $display("FAIL w_first_merge: got %h required AA22CC44", reg_q[63:32]);
        end
        checks++;
        if (last_b_lat !== 1) begin
            errors++; $display("FAIL w_first_b_latency: got %0d required 1", last_b_lat);
        end
        write_txn(6'h04, 32'hFFFFFFFF, 4'h0, 0, RESP_OKAY);
        checks++;
        if (reg_q[63:32] !== 32'hAA22CC44 || last_wr_pulse !== 8'h02) begin
            errors++; $display("FAIL strb_zero: reg=%h pulse=%h required AA22CC44 / 02", reg_q[63:32], last_wr_pulse);
        end
    endtask

    task automatic test_ro_status();
        ro_d[63:32] = 32'h0000_00A5;
        read_txn(6'h24, 32'h0000_00A5, RESP_OKAY, 0);
        checks++;
        if (last_rd_pulse !== 4'b0010 || post_rd_pulse !== 4'b0000) begin
            errors++; $display("FAIL ro_pulse: got %b then %b required 0010 then 0000", last_rd_pulse, post_rd_pulse);
        end
        write_txn(6'h24, 32'h12345678, 4'hF, 0, RESP_SLVERR);
        checks++;
        if (reg_q !== model_flat() || last_wr_pulse !== '0) begin
            errors++; $display("FAIL ro_write: reg_q=%h pulse=%h required %h / 00", reg_q, last_wr_pulse, model_flat());
        end
    endtask

    task automatic test_unmapped();
        read_txn(6'h3C, 32'h0, RESP_SLVERR, 0);
        checks++;
        if (last_rd_pulse !== 4'b0000) begin
            errors++; $display("FAIL unmapped_rd_pulse: got %b required 0000", last_rd_pulse);
        end
        write_txn(6'h3C, 32'hCAFEF00D, 4'hF, 0, RESP_SLVERR);
        checks++;
        if (reg_q !== model_flat() || last_wr_pulse !== '0) begin
            errors++; $display("FAIL unmapped_write: reg_q=%h required %h", reg_q, model_flat());
        end
    endtask

    task automatic test_b_stall();
        logic [DATA_W-1:0] old3;
        BREADY = 1'b0;
        send_aw_w(6'h08, 32'h01010101, 4'hF, 0, RESP_OKAY);
        old3 = model[3];
        send_aw_w(6'h0C, 32'h02020202, 4'hF, 0, RESP_OKAY);
        for (int i = 0; i < 10; i++) begin
            @(posedge ACLK); #1;
            checks++;
            if ({AWREADY, WREADY, BVALID} !== 3'b001 || reg_q[127:96] !== old3) begin
                errors++;
                $display("FAIL b_stall: aw/w/bvalid=%b reg3=%h required 001 / %h", {AWREADY, WREADY, BVALID}, reg_q[127:96], old3);
            end
        end
        wait_b();
        wait_b();
        checks++;
        if (reg_q !== model_flat()) begin
            errors++; $display("FAIL b_stall_final: reg_q=%h required %h", reg_q, model_flat());
        end
    endtask

    task automatic test_read_hold();
        read_txn(6'h04, model[1], RESP_OKAY, 3);
    endtask

    task automatic test_back_to_back();
        int idx;
        logic [DATA_W-1:0] d;
        logic [DATA_W/8-1:0] s;
        for (int t = 0; t < 12; t++) begin
            idx = $urandom_range(0, NUM_RW - 1);
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            write_txn(6'(idx * 4), d, s, $urandom_range(0, 2), RESP_OKAY);
            checks++;
            if (reg_q !== model_flat()) begin
                errors++; $display("FAIL b2b_reg_q: idx=%0d got %h required %h", idx, reg_q, model_flat());
            end
            idx = $urandom_range(0, NUM_RW - 1);
            read_txn(6'(idx * 4), model[idx], RESP_OKAY, 0);
            idx = $urandom_range(0, NUM_RO - 1);
            d   = $urandom;
            ro_d[idx*DATA_W +: DATA_W] = d;
            read_txn(6'((NUM_RW + idx) * 4), d, RESP_OKAY, 0);
        end
    endtask

    task automatic test_reset_mid_write();
        AWADDR = 6'h08; AWVALID = 1'b1; WVALID = 1'b0;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        checks++;
        if (AWREADY !== 1'b0 || WREADY !== 1'b1) begin
            errors++; $display("FAIL aw_slot_full: AWREADY=%0b WREADY=%0b required 0 / 1", AWREADY, WREADY);
        end
        #2 ARESETN = 1'b0;
        #1;
        for (int i = 0; i < NUM_RW; i++) model[i] = '0;
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0 || reg_q !== '0 || RDATA !== '0 || reg_wr_pulse !== '0) begin
            errors++;
            $display("FAIL async_reset: hs=%b reg_q=%h RDATA=%h required zeros", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, reg_q, RDATA);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        write_txn(6'h08, 32'h12345678, 4'hF, 0, RESP_OKAY);
        checks++;
        if (reg_q !== model_flat() || last_wr_pulse !== 8'h04) begin
            errors++; $display("FAIL post_reset_write: reg_q=%h pulse=%h required %h / 04", reg_q, last_wr_pulse, model_flat());
        end
        read_txn(6'h08, 32'h12345678, RESP_OKAY, 0);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        test_reset();
        test_basic_write_read();
        test_w_first_strobe();
        test_ro_status();
        test_unmapped();
        test_b_stall();
        test_read_hold();
        test_back_to_back();
        test_reset_mid_write();
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if (exp_bresp_q.size() != 0 || exp_rdata_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending b=%0d r=%0d required 0/0", exp_bresp_q.size(), exp_rdata_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
